highscore_update_ctrl: RTL
==========================

// Module: highscore_update_ctrl
// PURPOSE
//  Sequential controller owning the 5-entry high-score table. Accepts a
//  game-over event with the final score, scans the table one slot per
//  cycle, inserts the score with a single-cycle shift, then reports rank.
//  Sits between game FSM (score source) and leaderboard display (hi1..hi5).
// PARAMETERS
//  SCORE_W   8    score and table-entry width (unsigned)
//  HI1_INIT  141  slot 1 value after reset / clear
//  HI2_INIT  33   slot 2 value after reset / clear
//  HI3_INIT  20   slot 3 value after reset / clear
//  HI4_INIT  15   slot 4 value after reset / clear
//  HI5_INIT  11   slot 5 value after reset / clear
// PORTS
//  clock       in   1        system clock, all state on rising edge
//  resetn      in   1        asynchronous, active-low reset
//  game_over   in   1        1-cycle request: score on curr_score is final
//  curr_score  in   SCORE_W  score; sampled only in the game_over accept cycle
//  clear_req   in   1        1-cycle request: restore table to *_INIT values
//  hi1..hi5    out  SCORE_W  registered table, hi1 = best, non-increasing order
//  busy        out  1        high in SCAN/SHIFT/DONE; requests not accepted
//  done        out  1        1-cycle pulse: update or clear complete
//  new_rank    out  3        1..5 = slot taken, 0 = not placed/clear; held to next done
//  dropped     out  1        1-cycle pulse: a request was rejected
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE, hi1..hi5=HI*_INIT, busy=0, done=0,
//   new_rank=0, dropped=0, internal score latch and slot index = 0.
//   Reset mid-operation aborts: partial shift never visible.
//  FSM: IDLE -> SCAN -> SHIFT -> DONE -> IDLE; SCAN -> DONE if not placed.
//  IDLE: game_over=1 -> latch curr_score, idx=0, go SCAN (accept = cycle 0).
//   clear_req=1 -> table := *_INIT in that edge, new_rank=0, go DONE.
//   Both same cycle: clear wins, game_over dropped (dropped pulses).
//  SCAN: one slot per cycle; if score > hi[idx] (strict, unsigned) record
//   rank=idx+1, go SHIFT; else idx++; if idx was 4 -> rank=0, go DONE.
//   Ties never displace: equal score lands below existing entry.
//  SHIFT: single edge: slots below rank move down one, hi5 discarded,
//   slot rank := latched score. Table never shows a half-shifted state.
//  DONE: done=1 for exactly one cycle, new_rank updated same cycle, -> IDLE.
//  Latency (accept at cycle 0): placed in slot k -> SCAN cycles 1..k,
//   SHIFT cycle k+1, done high cycle k+2 (k=1:3 ... k=5:7).
//   Not placed -> SCAN cycles 1..5, done high cycle 6. Clear -> done cycle 1.
//  game_over or clear_req while busy=1: ignored, dropped=1 next cycle,
//   table and in-flight operation unaffected. No queueing.
//  busy rises the cycle after accept, falls the cycle after done.
//  curr_score changes after accept have no effect.
//  Table invariant hi1>=hi2>=hi3>=hi4>=hi5 holds at all times.
// TESTING
//  1 game_over, score=50 -> rank 2, done at cycle 4; table 141,50,33,20,15.
//  2 game_over, score=200 -> rank 1, done at cycle 3; table 200,141,33,20,15.
//  3 score=11 (equal hi5) -> new_rank 0, done at cycle 6, table unchanged;
//    score=12 -> rank 5, done cycle 7, hi5=12.
//  4 game_over score=16 then game_over score=99 at cycle 2 -> dropped pulse,
//    only 16 inserted (rank 4); clear_req+game_over same cycle -> clear wins.
//  5 after inserts, clear_req -> done cycle 1, table = 141,33,20,15,11.
//  6 resetn low during SHIFT for score=100 -> table = INIT values, busy=0,
//    no done pulse; next game_over processes normally.

Source files
------------

// File: rtl/highscore_update_ctrl.sv
// highscore_update_ctrl: owns the five-entry high-score table.
// A game-over request scans the table one slot per cycle. A qualifying score
// is inserted with a single-edge shift, and its rank is reported with a done
// pulse. A clear request restores the power-on table.
module highscore_update_ctrl #(
    parameter int          SCORE_W  = 8,
    parameter int unsigned HI1_INIT = 141,
    parameter int unsigned HI2_INIT = 33,
    parameter int unsigned HI3_INIT = 20,
    parameter int unsigned HI4_INIT = 15,
    parameter int unsigned HI5_INIT = 11
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               game_over,
    input  logic [SCORE_W-1:0] curr_score,
    input  logic               clear_req,
    output logic [SCORE_W-1:0] hi1,
    output logic [SCORE_W-1:0] hi2,
    output logic [SCORE_W-1:0] hi3,
    output logic [SCORE_W-1:0] hi4,
    output logic [SCORE_W-1:0] hi5,
    output logic               busy,
    output logic               done,
    output logic [2:0]         new_rank,
    output logic               dropped
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [SCORE_W-1:0] INIT_TBL [5] = '{
        SCORE_W'(HI1_INIT), SCORE_W'(HI2_INIT), SCORE_W'(HI3_INIT),
        SCORE_W'(HI4_INIT), SCORE_W'(HI5_INIT)
    };

    state_t             state;
    logic [SCORE_W-1:0] tbl [5];   // index 0 is the best score
    logic [SCORE_W-1:0] score_q;   // score captured on accept
    logic [2:0]         idx;       // slot currently being compared
    logic [2:0]         rank_q;    // 1-based slot the score will take

    assign hi1 = tbl[0];
    assign hi2 = tbl[1];
    assign hi3 = tbl[2];
    assign hi4 = tbl[3];
    assign hi5 = tbl[4];

    // Controller FSM: it updates the table and drives all registered status outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            // NOTE: the table is architectural state that the display reads, so it
            // is reset explicitly. This reset also discards any half-finished insert.
            tbl      <= INIT_TBL;
            score_q  <= '0;
            idx      <= '0;
            rank_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            new_rank <= '0;
            dropped  <= 1'b0;
        end else begin
            // NOTE: every state update uses non-blocking assignments. The SHIFT
            // step reads the old tbl[i-1] while it writes tbl[i] on the same edge.
            done    <= 1'b0;
            dropped <= 1'b0;

            // A request that arrives while busy is not queued. It is flagged and dropped.
            if (busy && (game_over || clear_req)) begin
                dropped <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (clear_req) begin
                        tbl      <= INIT_TBL;
                        rank_q   <= '0;
                        new_rank <= '0;
                        done     <= 1'b1;
                        busy     <= 1'b1;
                        dropped  <= game_over;
                        state    <= S_DONE;
                    end else if (game_over) begin
                        score_q <= curr_score;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    // The comparison is strict, so a tied score lands below the existing entry.
                    if (score_q > tbl[idx]) begin
                        rank_q <= idx + 3'd1;
                        state  <= S_SHIFT;
                    end else if (idx == 3'd4) begin
                        rank_q   <= '0;
                        new_rank <= '0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end

                S_SHIFT: begin
                    // The slots below the new rank move down one place, and the old hi5 falls off.
                    for (int i = 1; i < 5; i++) begin
                        if (3'(i) >= rank_q) begin
                            tbl[i] <= tbl[i-1];
                        end
                    end
                    tbl[rank_q - 3'd1] <= score_q;
                    new_rank           <= rank_q;
                    done               <= 1'b1;
                    state              <= S_DONE;
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
